// File: rtl/es_psk_pkg.sv
// Shared definitions for the PSK burst framer.
// Contents: framer state enum, CRC-24 generator, constellation sign tables
// with the 181/256 diagonal scale, and a Gray-to-binary helper.
package es_psk_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CRC  = 2'd1,
    S_PRE  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam int         CRC_W     = 24;
  localparam logic [24:0] CRC24_GEN = 25'h1FFF409;

  // Point p sits at 45 deg * p. Sign of each component per point:
  // 2'b01 = +, 2'b11 = -, 2'b00 = zero. Odd points use the diagonal magnitude.
  localparam logic [1:0] I_SGN [8] = '{2'b01, 2'b01, 2'b00, 2'b11,
                                       2'b11, 2'b11, 2'b00, 2'b01};
  localparam logic [1:0] Q_SGN [8] = '{2'b00, 2'b01, 2'b01, 2'b01,
                                       2'b00, 2'b11, 2'b11, 2'b11};
  localparam int DIAG_NUM   = 181;
  localparam int DIAG_SHIFT = 8;

  // Narrower symbols are zero-extended at the top, which the prefix XOR tolerates.
  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/es_psk_tx_framer_if.sv
// Handshake and sample bus of the PSK burst framer.
// master: message source / sample sink (drives data_in, start).
// slave : framer (drives ready, busy, sym_strobe, tx_valid, tx_i, tx_q, done).
interface es_psk_tx_framer_if #(
  parameter int PAYLOAD_BITS = 88,
  parameter int OUT_W        = 20
);
  logic [PAYLOAD_BITS-1:0] data_in;
  logic                    start;
  logic                    ready;
  logic                    busy;
  logic                    sym_strobe;
  logic                    tx_valid;
  logic signed [OUT_W-1:0] tx_i;
  logic signed [OUT_W-1:0] tx_q;
  logic                    done;

  modport master (output data_in, start,
                  input  ready, busy, sym_strobe, tx_valid, tx_i, tx_q, done);
  modport slave  (input  data_in, start,
                  output ready, busy, sym_strobe, tx_valid, tx_i, tx_q, done);
endinterface

// File: rtl/es_psk_mapper.sv
// Symbol-to-I/Q mapper with registered outputs.
// Ports: clk, rst (async active-high), clr (restart phase at frame accept),
//        vld/stb/k (symbol index and first-sample strobe),
//        tx_valid, sym_strobe, tx_i, tx_q (registered, zero when not valid).
// Build option ES_PSK_TX_DIFF_EN: phase accumulates k*(8/M) per symbol
// instead of absolute mapping.
module es_psk_mapper
  import es_psk_pkg::*;
#(
  parameter int BITS_PER_SYM = 3,
  parameter int OUT_W        = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    vld,
  input  logic                    stb,
  input  logic [2:0]              k,
  output logic                    tx_valid,
  output logic                    sym_strobe,
  output logic signed [OUT_W-1:0] tx_i,
  output logic signed [OUT_W-1:0] tx_q
);
  localparam longint AMP_L  = (longint'(1) << (OUT_W - 2)) - 1;
  localparam longint DIAG_L = (AMP_L * DIAG_NUM) >>> DIAG_SHIFT;
  localparam logic signed [OUT_W-1:0] AMP  = AMP_L[OUT_W-1:0];
  localparam logic signed [OUT_W-1:0] DIAG = DIAG_L[OUT_W-1:0];

  logic [2:0] inc;
  logic [2:0] p;
  logic signed [OUT_W-1:0] i_c, q_c;

  assign inc = k << (3 - BITS_PER_SYM);

`ifdef ES_PSK_TX_DIFF_EN
  logic [2:0] acc;
  // acc holds the current symbol's phase once its first sample has passed.
  assign p = stb ? (acc + inc) : acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              acc <= '0;
    else if (clr)         acc <= '0;
    else if (vld && stb)  acc <= p;
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign p = inc;
`endif

  function automatic logic signed [OUT_W-1:0] scale(input logic [1:0] sgn, input logic diag);
    logic signed [OUT_W-1:0] mag;
    mag = diag ? DIAG : AMP;
    case (sgn)
      2'b01:   scale = mag;
      2'b11:   scale = -mag;
      default: scale = '0;
    endcase
  endfunction

  always_comb begin
    i_c = scale(I_SGN[p], p[0]);
    q_c = scale(Q_SGN[p], p[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid   <= 1'b0;
      sym_strobe <= 1'b0;
      tx_i       <= '0;
      tx_q       <= '0;
    end else begin
      tx_valid   <= vld;
      sym_strobe <= vld && stb;
      tx_i       <= vld ? i_c : '0;
      tx_q       <= vld ? q_c : '0;
    end
  end
endmodule

// File: rtl/es_psk_tx_framer.sv
// 1090ES-style PSK burst framer: latches payload, runs serial CRC-24,
// emits preamble + {payload, crc, zero pad} as oversampled M-PSK I/Q.
// Ports: clk, rst (async active-high), bus (slave modport: data_in, start,
//        ready, busy, sym_strobe, tx_valid, tx_i, tx_q, done).
// Build option ES_PSK_TX_DIFF_EN: differential phase encoding (in mapper).
//
// state  | meaning
// IDLE   | ready, waiting for start
// CRC    | one payload bit per cycle through CRC-24
// PRE    | alternating 0/180 deg preamble symbols
// DATA   | frame symbols, MSB first
module es_psk_tx_framer
  import es_psk_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 88,
  parameter int BITS_PER_SYM  = 3,
  parameter int SPS           = 4,
  parameter int PREAMBLE_SYMS = 8,
  parameter int OUT_W         = 20
) (
  input logic               clk,
  input logic               rst,
  es_psk_tx_framer_if.slave bus
);
  localparam int FRAME_BITS = PAYLOAD_BITS + CRC_W;
  localparam int NSYM       = (FRAME_BITS + BITS_PER_SYM - 1) / BITS_PER_SYM;
  localparam int FW         = NSYM * BITS_PER_SYM;
  localparam int MAX_SYMS   = (NSYM > PREAMBLE_SYMS) ? NSYM : PREAMBLE_SYMS;
  localparam int BIT_W      = $clog2(PAYLOAD_BITS + 1);
  localparam int SYM_W      = $clog2(MAX_SYMS + 1);
  localparam int SMP_W      = $clog2(SPS + 1);
  localparam logic [2:0] HALF_M = 3'(2 ** (BITS_PER_SYM - 1));

  state_t                  state, state_nxt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SYM_W-1:0]        sym_cnt;
  logic [SMP_W-1:0]        smp_cnt;
  logic [PAYLOAD_BITS-1:0] pay, pay_rot;
  logic [CRC_W-1:0]        crc, crc_nxt;
  logic [FW-1:0]           frm, frm_load;
  logic                    busy, done, done_nxt;
  logic                    accept, crc_last, smp_wrap, pre_last;
  logic                    sym_vld, sym_stb;
  logic [2:0]              sym_k;
  logic                    s1_vld, s1_stb;
  logic [2:0]              s1_k;

  // Payload rotates rather than shifts so it is intact again after the CRC pass.
  always_comb begin
    pay_rot  = {pay[PAYLOAD_BITS-2:0], pay[PAYLOAD_BITS-1]};
    crc_nxt  = {crc[CRC_W-2:0], 1'b0} ^
               ((pay[PAYLOAD_BITS-1] ^ crc[CRC_W-1]) ? CRC24_GEN[CRC_W-1:0] : '0);
    frm_load = '0;
    frm_load[FW-1 -: FRAME_BITS] = {pay_rot, crc_nxt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sym_vld   = 1'b0;
    sym_stb   = 1'b0;
    sym_k     = '0;
    smp_wrap  = (smp_cnt == SMP_W'(SPS - 1));
    crc_last  = (bit_cnt == BIT_W'(PAYLOAD_BITS - 1));
    pre_last  = (sym_cnt == SYM_W'(PREAMBLE_SYMS - 1));
    case (state)
      S_IDLE: if (bus.start && !busy) begin
        accept    = 1'b1;
        state_nxt = S_CRC;
      end
      S_CRC: if (crc_last) state_nxt = S_PRE;
      S_PRE: begin
        sym_vld = 1'b1;
        sym_stb = (smp_cnt == '0);
        sym_k   = sym_cnt[0] ? HALF_M : 3'd0;
        if (smp_wrap && pre_last) state_nxt = S_DATA;
      end
      S_DATA: begin
        sym_vld = 1'b1;
        sym_stb = (smp_cnt == '0);
        sym_k   = gray2bin(3'(frm[FW-1 -: BITS_PER_SYM]));
        if (smp_wrap && sym_cnt == SYM_W'(NSYM - 1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Last sample has left the mapper while nothing follows in the symbol stage.
  assign done_nxt = busy && bus.tx_valid && !s1_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      sym_cnt <= '0;
      smp_cnt <= '0;
      pay     <= '0;
      crc     <= '0;
      frm     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s1_vld  <= 1'b0;
      s1_stb  <= 1'b0;
      s1_k    <= '0;
    end else begin
      s1_vld <= sym_vld;
      s1_stb <= sym_stb;
      s1_k   <= sym_k;
      done   <= done_nxt;
      if (accept)        busy <= 1'b1;
      else if (done_nxt) busy <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          pay     <= bus.data_in;
          crc     <= '0;
          bit_cnt <= '0;
        end
        S_CRC: begin
          pay     <= pay_rot;
          crc     <= crc_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (crc_last) begin
            frm     <= frm_load;
            sym_cnt <= '0;
            smp_cnt <= '0;
          end
        end
        default: begin
          smp_cnt <= smp_wrap ? '0 : smp_cnt + 1'b1;
          if (smp_wrap) begin
            sym_cnt <= (state == S_PRE && pre_last) ? '0 : sym_cnt + 1'b1;
            if (state == S_DATA) frm <= frm << BITS_PER_SYM;
          end
        end
      endcase
    end
  end

  es_psk_mapper #(
    .BITS_PER_SYM (BITS_PER_SYM),
    .OUT_W        (OUT_W)
  ) u_mapper (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .vld        (s1_vld),
    .stb        (s1_stb),
    .k          (s1_k),
    .tx_valid   (bus.tx_valid),
    .sym_strobe (bus.sym_strobe),
    .tx_i       (bus.tx_i),
    .tx_q       (bus.tx_q)
  );

  assign bus.ready = ~busy;
  assign bus.busy  = busy;
  assign bus.done  = done;
endmodule

// File: tb/tb_es_psk_tx_framer.sv
`timescale 1ns/1ps
module tb_es_psk_tx_framer;
  localparam int P = 88;
  localparam int W = 20;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  es_psk_tx_framer_if #(.PAYLOAD_BITS(P), .OUT_W(W)) bus0 ();
  es_psk_tx_framer_if #(.PAYLOAD_BITS(P), .OUT_W(W)) bus1 ();

  es_psk_tx_framer #(.PAYLOAD_BITS(P), .BITS_PER_SYM(3), .SPS(4), .PREAMBLE_SYMS(8), .OUT_W(W))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  es_psk_tx_framer #(.PAYLOAD_BITS(P), .BITS_PER_SYM(1), .SPS(1), .PREAMBLE_SYMS(5), .OUT_W(W))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_fail = 0;
  bit sel = 1'b0;
  int B, SPS, PRE, NSYM, T;
  int A, D;

  typedef struct { int i; int q; bit s; } smp_t;
  smp_t expq[$];
  int   obs_i[$];
  int   obs_q[$];

  logic o_valid, o_stb, o_done, o_ready, o_busy;
  logic signed [W-1:0] o_i, o_q;

  always_comb begin
    if (sel) begin
      o_valid = bus1.tx_valid; o_stb = bus1.sym_strobe; o_done = bus1.done;
      o_ready = bus1.ready; o_busy = bus1.busy; o_i = bus1.tx_i; o_q = bus1.tx_q;
    end else begin
      o_valid = bus0.tx_valid; o_stb = bus0.sym_strobe; o_done = bus0.done;
      o_ready = bus0.ready; o_busy = bus0.busy; o_i = bus0.tx_i; o_q = bus0.tx_q;
    end
  end

  task automatic drive(input bit st, input logic [P-1:0] d);
    if (sel) begin bus1.start = st; bus1.data_in = d; end
    else     begin bus0.start = st; bus0.data_in = d; end
  endtask

  task automatic set_cfg(input bit s);
    sel  = s;
    B    = s ? 1 : 3;
    SPS  = s ? 1 : 4;
    PRE  = s ? 5 : 8;
    NSYM = (P + 24 + B - 1) / B;
    T    = (PRE + NSYM) * SPS;
  endtask

  function automatic int comp(input real v);
    if (v > 0.9)  return A;
    if (v > 0.5)  return D;
    if (v < -0.9) return -A;
    if (v < -0.5) return -D;
    return 0;
  endfunction

  // Reference: CRC by polynomial long division, symbols from the frame bit list.
  task automatic build_model(input logic [P-1:0] pl);
    logic [P+23:0] m, frame;
    int M, p, k, g;
    real c, s;
    m = {pl, 24'b0};
    for (int i = P + 23; i >= 24; i--)
      if (m[i]) m[i -: 25] = m[i -: 25] ^ 25'h1FFF409;
    frame = {pl, m[23:0]};
    M = 1 << B;
    p = 0;
    expq.delete();
    for (int n = 0; n < PRE + NSYM; n++) begin
      if (n < PRE) k = (n % 2) ? M / 2 : 0;
      else begin
        g = 0;
        for (int j = 0; j < B; j++) begin
          int idx;
          idx = (n - PRE) * B + j;
          g = (g << 1) | ((idx < P + 24) ? int'(frame[P + 23 - idx]) : 0);
        end
        k = g ^ (g >> 1) ^ (g >> 2);
      end
`ifdef ES_PSK_TX_DIFF_EN
      p = (p + k * (8 / M)) % 8;
`else
      p = (k * (8 / M)) % 8;
`endif
      c = $cos(p * PI / 4.0);
      s = $sin(p * PI / 4.0);
      for (int t = 0; t < SPS; t++) expq.push_back('{comp(c), comp(s), t == 0});
    end
  endtask

  task automatic run_frame(input logic [P-1:0] pl, input bit hold, input bit noise, input string nm);
    int cyc, first, nv, done_at;
    smp_t e;
    build_model(pl);
    obs_i.delete(); obs_q.delete();
    drive(1'b1, pl);
    @(posedge clk); #1;
    drive(hold, pl);
    n_cmp++;
    if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: busy=%b ready=%b, required busy=1 ready=0", nm, o_busy, o_ready);
    end
    cyc = 0; first = -1; nv = 0; done_at = -1;
    while (done_at < 0 && cyc < P + T + 50) begin
      @(posedge clk); #1;
      cyc++;
      if (noise && !hold)
        drive((cyc < P + T) ? 1'($urandom_range(0, 1)) : 1'b0,
              P'({$urandom, $urandom, $urandom}));
      if (o_valid === 1'b1) begin
        if (first < 0) first = cyc;
        obs_i.push_back(int'(o_i));
        obs_q.push_back(int'(o_q));
        if (nv < expq.size()) begin
          e = expq[nv];
          n_cmp++;
          if (o_i !== W'(e.i) || o_q !== W'(e.q) || o_stb !== e.s) begin
            n_fail++;
            $display("FAIL %s sample %0d: i=%0d q=%0d stb=%b, required i=%0d q=%0d stb=%b",
                     nm, nv, o_i, o_q, o_stb, e.i, e.q, e.s);
          end
        end
        nv++;
      end else begin
        n_cmp++;
        if (o_i !== '0 || o_q !== '0 || o_stb !== 1'b0) begin
          n_fail++;
          $display("FAIL %s idle_zero cycle %0d: i=%0d q=%0d stb=%b, required 0", nm, cyc, o_i, o_q, o_stb);
        end
      end
      if (o_done === 1'b1) done_at = cyc;
    end
    n_cmp++;
    if (first != P + 2) begin
      n_fail++; $display("FAIL %s first_valid: E%0d, required E%0d", nm, first, P + 2);
    end
    n_cmp++;
    if (nv != T) begin
      n_fail++; $display("FAIL %s valid_count: %0d, required %0d", nm, nv, T);
    end
    n_cmp++;
    if (done_at != P + 2 + T) begin
      n_fail++; $display("FAIL %s done_cycle: E%0d, required E%0d", nm, done_at, P + 2 + T);
    end
    n_cmp++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release: busy=%b ready=%b, required busy=0 ready=1", nm, o_busy, o_ready);
    end
    if (!hold) begin
      @(posedge clk); #1;
      n_cmp++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s after_done: done=%b busy=%b valid=%b, required 0 0 0", nm, o_done, o_busy, o_valid);
      end
    end
  endtask

  task automatic check_idle(input string nm);
    n_cmp++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_stb !== 1'b0 ||
        o_done !== 1'b0 || o_i !== '0 || o_q !== '0) begin
      n_fail++;
      $display("FAIL %s: ready=%b busy=%b valid=%b stb=%b done=%b i=%0d q=%0d, required 1 0 0 0 0 0 0",
               nm, o_ready, o_busy, o_valid, o_stb, o_done, o_i, o_q);
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      set_cfg(s[0]); #1;
      check_idle(s == 0 ? "reset_dut0" : "reset_dut1");
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      set_cfg(s[0]); #1;
      check_idle(s == 0 ? "post_reset_dut0" : "post_reset_dut1");
    end
  endtask

  task automatic test_known_vector;
    set_cfg(1'b0);
    run_frame(88'h8D4840D6202CC371C32CE0, 1'b0, 1'b0, "known_vector");
  endtask

  task automatic test_constellation;
    logic [P-1:0] pl;
    int ei[4], eq[4], idx;
    set_cfg(1'b0);
    pl = {12'h05A, 76'({$urandom, $urandom, $urandom})};
`ifdef ES_PSK_TX_DIFF_EN
    ei = '{A, D, -D, 0};  eq = '{0, D, D, -A};
`else
    ei = '{A, D, 0, -D};  eq = '{0, D, A, D};
`endif
    run_frame(pl, 1'b0, 1'b0, "constellation");
    for (int s = 0; s < 4; s++) begin
      idx = (PRE + s) * SPS;
      n_cmp++;
      if (idx >= obs_i.size() || obs_i[idx] != ei[s] || obs_q[idx] != eq[s]) begin
        n_fail++;
        $display("FAIL constellation sym%0d: i=%0d q=%0d, required i=%0d q=%0d",
                 s, (idx < obs_i.size()) ? obs_i[idx] : 0, (idx < obs_q.size()) ? obs_q[idx] : 0, ei[s], eq[s]);
      end
    end
  endtask

  task automatic test_random_busy_start;
    set_cfg(1'b0);
    for (int n = 0; n < 3; n++) run_frame(P'({$urandom, $urandom, $urandom}), 1'b0, 1'b1, "random_busy_start");
  endtask

  task automatic test_back_to_back;
    set_cfg(1'b0);
    run_frame(P'({$urandom, $urandom, $urandom}), 1'b1, 1'b0, "b2b_0");
    run_frame(P'({$urandom, $urandom, $urandom}), 1'b1, 1'b0, "b2b_1");
    run_frame(P'({$urandom, $urandom, $urandom}), 1'b0, 1'b0, "b2b_2");
  endtask

  task automatic test_reset_mid_frame;
    int dones;
    logic [P-1:0] pl;
    set_cfg(1'b0);
    pl = P'({$urandom, $urandom, $urandom});
    drive(1'b1, pl);
    @(posedge clk); #1;
    drive(1'b0, pl);
    repeat (P + 2 + PRE * SPS + 10) @(posedge clk);
    #1;
    n_cmp++;
    if (o_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_frame_valid: valid=%b, required 1", o_valid);
    end
    rst = 1'b1;
    #1;
    check_idle("reset_in_data");
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1 || o_valid === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_fail++; $display("FAIL reset_no_done: %0d active cycles, required 0", dones);
    end
    run_frame(P'({$urandom, $urandom, $urandom}), 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_bpsk;
    set_cfg(1'b1);
    run_frame('0, 1'b0, 1'b0, "bpsk_zero");
    run_frame(P'({$urandom, $urandom, $urandom}), 1'b0, 1'b1, "bpsk_random");
  endtask

  initial begin
    A = (1 << (W - 2)) - 1;
    D = int'((longint'(A) * 181) >>> 8);
    bus0.start = 1'b0; bus0.data_in = '0;
    bus1.start = 1'b0; bus1.data_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_known_vector;
    test_constellation;
    test_random_busy_start;
    test_back_to_back;
    test_reset_mid_frame;
    test_bpsk;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
